// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit:
// FSM states, step counts and the radix-4 Booth digit decode.
package multdiv_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MUL_STEPS  = DATA_WIDTH / 2;
    localparam int DIV_STEPS  = DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_sel_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_sel_t booth_decode(input logic [2:0] window);
        booth_sel_t sel;
        case (window)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multdiv_seq_if.sv
// Execute-stage multdiv handshake bundle; master is the processor,
// slave is the multiply/divide unit.
interface multdiv_seq_if
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);

    // Handshake: ctrl_MULT/ctrl_DIV act as a one-cycle valid with operands
    // captured on that edge; there is no ready -- a new start always wins and
    // aborts any op in flight. data_resultRDY is a one-cycle completion pulse,
    // and data_result/data_exception stay stable until the next completion.
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/booth_r4_step.sv
// Radix-4 Booth partial-product generator: picks 0, +-A or +-2A from the
// 3-bit multiplier window. Multiplicand arrives sign-extended by two bits.
module booth_r4_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+1:0] mcand,
    output logic [WIDTH+1:0] pp
);

    always_comb begin
        pp = '0;
        case (booth_decode(window))
            POS1:    pp = mcand;
            POS2:    pp = mcand << 1;
            NEG1:    pp = -mcand;
            NEG2:    pp = -(mcand << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Define MULTDIV_EARLY_OUT_EN to skip the iterations when an operand is zero.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_seq_if.slave   bus,
    output state_t         dbg_state
);

    localparam int CNT_W = $clog2(DIV_STEPS);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               op_mul;
    // acc: Booth high half / divider partial remainder.
    // work: multiplier then product low half / dividend then quotient.
    logic [WIDTH+1:0]   acc;
    logic [WIDTH-1:0]   work;
    logic               prev;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;

    logic               start;
    logic               zero_skip;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH+1:0]   mcand_ext;
    logic [WIDTH+1:0]   pp;
    logic [WIDTH+1:0]   mul_sum;
    logic [2*WIDTH+1:0] mul_shift;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_rem;
    logic [WIDTH:0]     prod_top;
    logic               neg;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_exc;

    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign dbg_state = state;

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state == DONE);

`ifdef MULTDIV_EARLY_OUT_EN
    assign zero_skip = (a_reg == '0) || (b_reg == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // Booth step: add partial product into the high half, then shift the
    // whole {acc, work} pair right arithmetically by two.
    assign mcand_ext = {{2{a_reg[WIDTH-1]}}, a_reg};
    assign mul_sum   = acc + pp;
    assign mul_shift = $signed({mul_sum, work}) >>> 2;

    booth_r4_step #(.WIDTH(WIDTH)) u_booth (
        .window ({work[1:0], prev}),
        .mcand  (mcand_ext),
        .pp     (pp)
    );

    // Non-restoring step on magnitudes; quotient bit is the new remainder's sign.
    assign a_mag_in  = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign b_mag     = b_reg[WIDTH-1] ? -b_reg : b_reg;
    assign div_shift = {acc[WIDTH:0], work[WIDTH-1]};
    assign div_rem   = acc[WIDTH+1] ? div_shift + {2'b00, b_mag}
                                    : div_shift - {2'b00, b_mag};

    assign prod_top = {acc[WIDTH-1:0], work[WIDTH-1]};
    assign neg      = a_reg[WIDTH-1] ^ b_reg[WIDTH-1];

    always_comb begin
        fix_result = '0;
        fix_exc    = 1'b0;
        if (op_mul) begin
            if (!zero_skip) begin
                fix_result = work;
                fix_exc    = !((&prod_top) || !(|prod_top));
            end
        end else if (b_reg == '0) begin
            fix_exc = 1'b1;
        end else if (!zero_skip) begin
            fix_result = neg ? -work : work;
            // Only 0x80000000 / -1 yields a positive quotient with the MSB set.
            fix_exc    = !neg && work[WIDTH-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = bus.ctrl_MULT ? MUL : DIV;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                MUL: begin
                    if (zero_skip || cnt == CNT_W'(MUL_STEPS - 1)) state_next = FIX;
                end
                DIV: begin
                    if (zero_skip || cnt == CNT_W'(DIV_STEPS - 1)) state_next = FIX;
                end
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_mul   <= 1'b0;
            acc      <= '0;
            work     <= '0;
            prev     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            a_reg  <= bus.data_operandA;
            b_reg  <= bus.data_operandB;
            op_mul <= bus.ctrl_MULT;
            acc    <= '0;
            work   <= bus.ctrl_MULT ? bus.data_operandB : a_mag_in;
            prev   <= 1'b0;
        end else begin
            case (state)
                MUL: begin
                    if (!zero_skip) begin
                        acc  <= mul_shift[2*WIDTH+1:WIDTH];
                        work <= mul_shift[WIDTH-1:0];
                        prev <= work[1];
                        cnt  <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (!zero_skip) begin
                        acc  <= div_rem;
                        work <= {work[WIDTH-2:0], ~div_rem[WIDTH+1]};
                        cnt  <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    result_q <= fix_result;
                    exc_q    <= fix_exc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed cases plus randomized ops
// against an arithmetic reference model. Honours MULTDIV_EARLY_OUT_EN.
module tb_multdiv_seq;
    import multdiv_pkg::*;

    localparam int W = 32;

    logic   clock = 1'b0;
    logic   reset;
    state_t dbg_state;
    int     checks = 0;
    int     errors = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_exc_q[$];

    multdiv_seq_if #(.WIDTH(W)) bus ();

    multdiv_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: wide signed arithmetic, exception when the value leaves 32-bit signed range.
    function automatic logic [W:0] ref_model(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p > 64'sh7FFF_FFFF) || (p < -64'sh8000_0000), p[W-1:0]};
        end
        if (b == '0) return {1'b1, {W{1'b0}}};
        p = longint'($signed(a)) / longint'($signed(b));
        return {(p > 64'sh7FFF_FFFF), p[W-1:0]};
    endfunction

    function automatic int latency(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULTDIV_EARLY_OUT_EN
        if (a == '0 || b == '0) return 2;
`endif
        return is_mul ? 17 : 33;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        int v;
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: begin v = $urandom_range(0, 200); return v - 100; end
            2: return '0;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom & 32'h0000_FFFF;
        endcase
    endfunction

    // driver tasks
    task automatic pulse_start(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        check("rdy_after_start", W'(bus.data_resultRDY), '0);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            check(tag, W'(bus.data_resultRDY), '0);
        end
    endtask

    // scoreboard: RDY must be high exactly lat edges after the start edge
    task automatic expect_done(input int lat);
        logic [W-1:0] er;
        logic         ee;
        er = exp_q.pop_front();
        ee = exp_exc_q.pop_front();
        for (int k = 1; k <= lat; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("rdy_timing", W'(bus.data_resultRDY), W'(k == lat));
        end
        check("result", bus.data_result, er);
        check("exception", W'(bus.data_exception), W'(ee));
        @(posedge clock);
        @(negedge clock);
        check("rdy_drop", W'(bus.data_resultRDY), '0);
        check("result_hold", bus.data_result, er);
        check("state_idle", W'(dbg_state), W'(IDLE));
    endtask

    task automatic run_exp(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int lat, input logic [W-1:0] er, input logic ee);
        exp_q.push_back(er);
        exp_exc_q.push_back(ee);
        pulse_start(m, d, a, b);
        expect_done(lat);
    endtask

    task automatic run_rand(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        r = ref_model(m, a, b);
        exp_q.push_back(r[W-1:0]);
        exp_exc_q.push_back(r[W]);
        pulse_start(m, d, a, b);
        expect_done(latency(m, a, b));
    endtask

    initial begin
        bit m;
        bit d;
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset_result", bus.data_result, '0);
        check("reset_exc", W'(bus.data_exception), '0);
        check("reset_rdy", W'(bus.data_resultRDY), '0);
        check("reset_state", W'(dbg_state), W'(IDLE));
        reset = 1'b0;

        run_exp(1, 0, 32'd7, 32'hFFFF_FFFD, latency(1, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB, 1'b0);
        run_exp(0, 1, 32'hFFFF_FF9C, 32'd7, latency(0, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2, 1'b0);
        run_exp(0, 1, 32'd100, 32'd0, latency(0, 32'd100, 32'd0), 32'd0, 1'b1);
        run_exp(1, 0, 32'h0001_0000, 32'h0001_0000, 17, 32'd0, 1'b1);
        run_exp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1);
        run_exp(1, 0, 32'h7FFF_FFFF, 32'd2, 17, 32'hFFFF_FFFE, 1'b1);

        // abort a multiply with a divide started at N+8
        pulse_start(1, 0, 32'd5, 32'd5);
        idle_cycles(6, "abort_no_rdy");
        run_exp(0, 1, 32'd20, 32'd4, 33, 32'd5, 1'b0);

        // both starts together: multiply wins
        run_exp(1, 1, 32'd6, 32'd3, 17, 32'd18, 1'b0);

        // asynchronous reset in the middle of a divide
        pulse_start(0, 1, 32'd1000, 32'd3);
        idle_cycles(9, "pre_reset_no_rdy");
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_result", bus.data_result, '0);
        check("async_reset_exc", W'(bus.data_exception), '0);
        check("async_reset_rdy", W'(bus.data_resultRDY), '0);
        check("async_reset_state", W'(dbg_state), W'(IDLE));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        idle_cycles(40, "no_rdy_after_reset");
        run_exp(0, 1, 32'd1000, 32'd3, 33, 32'd333, 1'b0);

        // zero operands: early-out timing when enabled, fixed timing otherwise
        run_exp(1, 0, 32'd0, 32'd123, latency(1, 32'd0, 32'd123), 32'd0, 1'b0);
        run_exp(0, 1, 32'd0, 32'd9, latency(0, 32'd0, 32'd9), 32'd0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       begin m = 1'b1; d = 1'b0; end
                1:       begin m = 1'b0; d = 1'b1; end
                default: begin m = 1'b1; d = 1'b1; end
            endcase
            run_rand(m, d, rand_operand(), rand_operand());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
